// File: rtl/hwregs_pkg.sv
// Shared types for the hardware-register bus arbiter.
package hwregs_pkg;

   localparam int unsigned HWREGS_RTAG_W = 9;

   // One hardware-register bus request as carried through the FIFO and issue stage.
   typedef struct packed {
      logic        write;
      logic [15:0] addr;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } hwregs_req_t;

   // Which requester owns an issued request.
   typedef enum logic {
      SRC_CPU = 1'b0,
      SRC_COP = 1'b1
   } hwregs_src_t;

endpackage

// File: rtl/hwregs_req_fifo.sv
// Request FIFO decoupling the fire-and-forget CPU port from the arbiter.
module hwregs_req_fifo
   import hwregs_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  hwregs_req_t                push_data,
   input  logic                       pop,
   output hwregs_req_t                head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       overflow
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   hwregs_req_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          push_ok, pop_ok;

   // Accept/drop decision plus pointer, count and full next state.
   always_comb begin
      pop_ok   = pop && (count_q != '0);
      // A full FIFO still takes a push when the head leaves in the same cycle.
      push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
      overflow = push && !push_ok;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == CW'(DEPTH));
   end

   // Pointer, occupancy and full-flag state.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   // Entry storage; no reset needed since occupancy gates what is visible.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = full_q;

endmodule

// File: rtl/hwregs_arbiter.sv
// Shares the hardware-register bus between the CPU (via a FIFO) and the copper.
module hwregs_arbiter
   import hwregs_pkg::*;
#(
   parameter int unsigned CPU_FIFO_DEPTH = 4,
   parameter int unsigned MAX_STARVE     = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cpu_request,
   input  logic                     cpu_write,
   input  logic [15:0]              cpu_addr,
   input  logic [3:0]               cpu_wmask,
   input  logic [31:0]              cpu_wdata,
   output logic                     cpu_full,
   output logic                     cpu_rvalid,
   output logic [HWREGS_RTAG_W-1:0] cpu_rtag,
   output logic [31:0]              cpu_rdata,
   input  logic                     cop_request,
   input  logic                     cop_write,
   input  logic [15:0]              cop_addr,
   input  logic [31:0]              cop_wdata,
   output logic                     cop_ready,
   output logic                     cop_rvalid,
   output logic [31:0]              cop_rdata,
   output logic                     hwregs_request,
   output logic                     hwregs_write,
   output logic [15:0]              hwregs_addr,
   output logic [3:0]               hwregs_wmask,
   output logic [31:0]              hwregs_wdata,
   input  logic                     hwregs_rvalid,
   input  logic [HWREGS_RTAG_W-1:0] hwregs_rtag,
   input  logic [31:0]              hwregs_rdata,
   input  logic                     status_clear,
   output logic [1:0]               status
);

   localparam int unsigned SW = $clog2(MAX_STARVE + 1);
   localparam int unsigned CW = $clog2(CPU_FIFO_DEPTH + 1);

   hwregs_req_t   cpu_push_data, cpu_head;
   logic [CW-1:0] cpu_count;
   logic          cpu_pending, cpu_overflow;
   logic          gnt_cpu, gnt_cop, starved, unexpected;
   logic [SW-1:0] starve_q, starve_d;
   hwregs_req_t   issue_q, issue_d;
   logic          req_q, req_d;
   hwregs_src_t   src_q, src_d;
   logic          pend_valid_q, pend_valid_d;
   hwregs_src_t   pend_src_q, pend_src_d;
   logic [1:0]    status_q, status_d;

   // Pack the CPU strobe fields into a FIFO entry.
   always_comb begin
      cpu_push_data       = '0;
      cpu_push_data.write = cpu_write;
      cpu_push_data.addr  = cpu_addr;
      cpu_push_data.wmask = cpu_wmask;
      cpu_push_data.wdata = cpu_wdata;
   end

   hwregs_req_fifo #(
      .DEPTH (CPU_FIFO_DEPTH)
   ) u_cpu_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (cpu_request),
      .push_data (cpu_push_data),
      .pop       (gnt_cpu),
      .head      (cpu_head),
      .count     (cpu_count),
      .full      (cpu_full),
      .overflow  (cpu_overflow)
   );

   assign cpu_pending = (cpu_count != '0);

   // Priority arbitration: CPU first unless the copper has waited MAX_STARVE cycles.
   always_comb begin
      starved = (starve_q == SW'(MAX_STARVE));
      gnt_cpu = 1'b0;
      gnt_cop = 1'b0;
      // Nothing is granted while reset is held so no output strobes during reset.
      if (reset) begin
         if (starved && cop_request) begin
            gnt_cop = 1'b1;
         end else if (cpu_pending) begin
            gnt_cpu = 1'b1;
         end else if (cop_request) begin
            gnt_cop = 1'b1;
         end
      end
      if (!cop_request || gnt_cop) begin
         starve_d = '0;
      end else if (!starved) begin
         starve_d = starve_q + SW'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   assign cop_ready = gnt_cop;

   // Issue stage next state; bus fields hold their last value when idle.
   always_comb begin
      issue_d = issue_q;
      src_d   = src_q;
      req_d   = 1'b0;
      if (gnt_cpu) begin
         issue_d = cpu_head;
         src_d   = SRC_CPU;
         req_d   = 1'b1;
      end else if (gnt_cop) begin
         issue_d.write = cop_write;
         issue_d.addr  = cop_addr;
         issue_d.wmask = 4'hF;
         issue_d.wdata = cop_write ? cop_wdata : 32'h0;
         src_d         = SRC_COP;
         req_d         = 1'b1;
      end
      // hwregs answers a read exactly one cycle after it is presented.
      pend_valid_d = req_q && !issue_q.write;
      pend_src_d   = src_q;
   end

   // Response routing and sticky status next state.
   always_comb begin
      cpu_rvalid = hwregs_rvalid && pend_valid_q && (pend_src_q == SRC_CPU);
      cop_rvalid = hwregs_rvalid && pend_valid_q && (pend_src_q == SRC_COP);
      cpu_rtag   = hwregs_rtag;
      cpu_rdata  = cpu_rvalid ? hwregs_rdata : 32'h0;
      cop_rdata  = cop_rvalid ? hwregs_rdata : 32'h0;
      unexpected = hwregs_rvalid && !pend_valid_q;
      // Set beats clear when both happen in one cycle.
      status_d   = (status_q & ~{2{status_clear}}) | {unexpected, cpu_overflow};
   end

   // Arbiter, issue, pending-read and status state.
   always_ff @(posedge clock) begin
      if (!reset) begin
         starve_q     <= '0;
         issue_q      <= '0;
         req_q        <= 1'b0;
         src_q        <= SRC_CPU;
         pend_valid_q <= 1'b0;
         pend_src_q   <= SRC_CPU;
         status_q     <= 2'b00;
      end else begin
         starve_q     <= starve_d;
         issue_q      <= issue_d;
         req_q        <= req_d;
         src_q        <= src_d;
         pend_valid_q <= pend_valid_d;
         pend_src_q   <= pend_src_d;
         status_q     <= status_d;
      end
   end

   assign hwregs_request = req_q;
   assign hwregs_write   = issue_q.write;
   assign hwregs_addr    = issue_q.addr;
   assign hwregs_wmask   = issue_q.wmask;
   assign hwregs_wdata   = issue_q.wdata;
   assign status         = status_q;

endmodule
